// File: rtl/fp16_add64_arbiter_if.sv
// Bundle of every requester-, tree- and result-side signal of the FP16 adder-tree arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding design.
interface fp16_add64_arbiter_if #(
    parameter int TAG_DEPTH = 16
);
    localparam int CW = $clog2(TAG_DEPTH) + 1;

    logic [1023:0] req0_x;
    logic [1023:0] req1_x;
    logic          req0_valid;
    logic          req1_valid;
    logic          req0_ready;
    logic          req1_ready;
    logic [1023:0] tree_x;
    logic          tree_valid;
    logic          tree_ready;
    logic [15:0]   tree_sum;
    logic          tree_sum_valid;
    logic          tree_next_ready;
    logic [15:0]   res0_sum;
    logic [15:0]   res1_sum;
    logic          res0_valid;
    logic          res1_valid;
    logic          res0_ready;
    logic          res1_ready;
    logic [CW-1:0] inflight;
    logic          tag_err;

    modport slave (
        input  req0_x, req1_x, req0_valid, req1_valid,
        output req0_ready, req1_ready,
        output tree_x, tree_valid,
        input  tree_ready, tree_sum, tree_sum_valid,
        output tree_next_ready,
        output res0_sum, res1_sum, res0_valid, res1_valid,
        input  res0_ready, res1_ready,
        output inflight, tag_err
    );

    modport master (
        output req0_x, req1_x, req0_valid, req1_valid,
        input  req0_ready, req1_ready,
        input  tree_x, tree_valid,
        output tree_ready, tree_sum, tree_sum_valid,
        input  tree_next_ready,
        input  res0_sum, res1_sum, res0_valid, res1_valid,
        output res0_ready, res1_ready,
        input  inflight, tag_err
    );
endinterface

// File: rtl/fp16_add64_arbiter.sv
// Round-robin sharing of one 64-input FP16 adder tree between two requesters.
// Issued requester IDs go into an in-order tag FIFO that steers each returning sum.
//
// state | meaning
// IDLE  | free to arbitrate between the current valids
// HOLD  | an offered vector was stalled by the tree; keep offering it until issue
module fp16_add64_arbiter #(
    parameter int TAG_DEPTH = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    fp16_add64_arbiter_if.slave bus
);
    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]           state;
    logic                 last_gnt;
    logic                 hold_gnt;
    logic [TAG_DEPTH-1:0] tag_mem;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 tag_err_q;

    logic grant;
    logic gnt_valid;
    logic tag_full;
    logic tag_empty;
    logic issue;
    logic pop;
    logic head;
    logic head_ready;

    // Grant depends only on registered state and the current valids
    always_comb begin
        grant = 1'b0;
        if (state == ST_HOLD)
            grant = hold_gnt;
        else if (bus.req0_valid && bus.req1_valid)
            grant = ~last_gnt;
        else if (bus.req1_valid)
            grant = 1'b1;
    end

    assign tag_full  = (count == CW'(TAG_DEPTH));
    assign tag_empty = (count == '0);
    assign gnt_valid = grant ? bus.req1_valid : bus.req0_valid;

    // Forward path; rst_n gating keeps every handshake low while reset is held
    assign bus.tree_x     = grant ? bus.req1_x : bus.req0_x;
    assign bus.tree_valid = rst_n & gnt_valid & ~tag_full;
    assign bus.req0_ready = rst_n & ~grant & bus.tree_ready & ~tag_full;
    assign bus.req1_ready = rst_n &  grant & bus.tree_ready & ~tag_full;
    assign issue          = bus.tree_valid & bus.tree_ready;

    // Return path steered by the oldest outstanding tag
    assign head                = tag_mem[rd_ptr];
    assign head_ready          = head ? bus.res1_ready : bus.res0_ready;
    assign bus.res0_sum        = bus.tree_sum;
    assign bus.res1_sum        = bus.tree_sum;
    assign bus.res0_valid      = bus.tree_sum_valid & ~tag_empty & ~head;
    assign bus.res1_valid      = bus.tree_sum_valid & ~tag_empty &  head;
    assign bus.tree_next_ready = ~tag_empty & head_ready;
    assign pop                 = bus.tree_sum_valid & bus.tree_next_ready;

    assign bus.inflight = count;
    assign bus.tag_err  = tag_err_q;

    // Arbitration state: remember the last issue, latch a stalled offer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            last_gnt <= 1'b1;
            hold_gnt <= 1'b0;
        end else if (issue) begin
            state    <= ST_IDLE;
            last_gnt <= grant;
        end else if (bus.tree_valid) begin
            state    <= ST_HOLD;
            hold_gnt <= grant;
        end
    end

    // Tag FIFO; full blocks the push even when a pop happens in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_mem <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (issue) begin
                tag_mem[wr_ptr] <= grant;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({issue, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky flag for a result that has no outstanding tag to route it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tag_err_q <= 1'b0;
        else if (bus.tree_sum_valid && tag_empty)
            tag_err_q <= 1'b1;
    end
endmodule

// File: tb/tb_fp16_add64_arbiter.sv
// Directed bench for the FP16 adder-tree arbiter with a latency-6 elastic tree model
// and per-requester scoreboards of expected sums.
module tb_fp16_add64_arbiter;
    localparam int DEPTH = 4;
    localparam int LAT   = 6;

    typedef struct {
        logic [15:0] sum;
        int          t;
    } tree_ent_t;

    logic clk = 1'b0;
    logic rst_n;
    logic inject;
    logic model_v;
    logic [15:0] model_sum;
    int   cyc;
    int   checks = 0;
    int   errors = 0;

    tree_ent_t   tq[$];
    logic [15:0] exp0[$];
    logic [15:0] exp1[$];
    int          issue_log[$];

    fp16_add64_arbiter_if #(.TAG_DEPTH(DEPTH)) bus ();

    fp16_add64_arbiter #(.TAG_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.tree_sum_valid = model_v | inject;
    assign bus.tree_sum       = inject ? 16'h1234 : model_sum;

    function automatic logic [1023:0] fill(input logic [15:0] v);
        return {64{v}};
    endfunction

    // Sum of 64 equal FP16 values: exponent rises by 6
    function automatic logic [15:0] sum64(input logic [15:0] v);
        return v + 16'h1800;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Tree model and issue recording; inputs are stable here since stimulus changes at negedge
    always @(posedge clk) begin
        tree_ent_t e;
        if (!rst_n) begin
            tq.delete();
            exp0.delete();
            exp1.delete();
        end else begin
            if (model_v && bus.tree_next_ready)
                void'(tq.pop_front());
            if (bus.tree_valid && bus.tree_ready) begin
                e.sum = sum64(bus.tree_x[15:0]);
                e.t   = cyc + LAT;
                tq.push_back(e);
            end
            if (bus.req0_valid && bus.req0_ready) begin
                issue_log.push_back(0);
                exp0.push_back(sum64(bus.req0_x[15:0]));
            end
            if (bus.req1_valid && bus.req1_ready) begin
                issue_log.push_back(1);
                exp1.push_back(sum64(bus.req1_x[15:0]));
            end
        end
        cyc++;
        model_v   = (tq.size() > 0) && (tq[0].t <= cyc);
        model_sum = (tq.size() > 0) ? tq[0].sum : 16'h0000;
    end

    // Scoreboard: compare each sum that will be accepted at the coming edge
    always @(negedge clk) begin
        #3;
        if (rst_n && !inject && bus.res0_valid && bus.res0_ready) begin
            check("res0_avail", 64'(exp0.size() > 0), 64'd1);
            if (exp0.size() > 0) check("res0_sum", 64'(bus.res0_sum), 64'(exp0.pop_front()));
        end
        if (rst_n && !inject && bus.res1_valid && bus.res1_ready) begin
            check("res1_avail", 64'(exp1.size() > 0), 64'd1);
            if (exp1.size() > 0) check("res1_sum", 64'(bus.res1_sum), 64'(exp1.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic drain(input string tag);
        int n = 0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.res0_ready = 1'b1;
        bus.res1_ready = 1'b1;
        bus.tree_ready = 1'b1;
        while ((bus.inflight != 0 || tq.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        #1;
        check({tag, "_inflight"}, 64'(bus.inflight), 64'd0);
        check({tag, "_exp0"}, 64'(exp0.size()), 64'd0);
        check({tag, "_exp1"}, 64'(exp1.size()), 64'd0);
    endtask

    initial begin
        cyc       = 0;
        model_v   = 1'b0;
        model_sum = 16'h0000;
        inject    = 1'b0;
        rst_n     = 1'b0;
        bus.req0_x     = fill(16'h3C00);
        bus.req1_x     = fill(16'h4000);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.tree_ready = 1'b1;
        bus.res0_ready = 1'b1;
        bus.res1_ready = 1'b1;

        // Reset state with both requests pending
        @(negedge clk); #1;
        check("rst_req0_ready", 64'(bus.req0_ready), 64'd0);
        check("rst_req1_ready", 64'(bus.req1_ready), 64'd0);
        check("rst_tree_valid", 64'(bus.tree_valid), 64'd0);
        check("rst_next_ready", 64'(bus.tree_next_ready), 64'd0);
        check("rst_res_valid", 64'({bus.res0_valid, bus.res1_valid}), 64'd0);
        check("rst_inflight", 64'(bus.inflight), 64'd0);
        check("rst_tag_err", 64'(bus.tag_err), 64'd0);

        // Alternation: 8 issues from two always-valid requesters
        rst_n = 1'b1;
        #1;
        check("first_grant_req0", 64'(bus.req0_ready), 64'd1);
        for (int n = 0; n < 200 && issue_log.size() < 8; n++) @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("alt_count", 64'(issue_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < issue_log.size(); i++)
            check($sformatf("alt_order_%0d", i), 64'(issue_log[i]), 64'(i % 2));
        drain("alt");

        // Hold stability: req1 stalled, req0 arrives later and must wait
        issue_log.delete();
        @(negedge clk);
        bus.req0_x     = fill(16'h3C00);
        bus.req1_x     = fill(16'h4000);
        bus.req1_valid = 1'b1;
        bus.tree_ready = 1'b0;
        #1;
        check("hold_tree_valid", 64'(bus.tree_valid), 64'd1);
        @(negedge clk);
        bus.req0_valid = 1'b1;
        #1;
        check("hold_tree_x", (bus.tree_x === fill(16'h4000)) ? 64'd1 : 64'd0, 64'd1);
        check("hold_req0_ready", 64'(bus.req0_ready), 64'd0);
        @(negedge clk);
        bus.tree_ready = 1'b1;
        #1;
        check("hold_req1_issue", 64'(bus.req1_ready), 64'd1);
        check("hold_req0_wait", 64'(bus.req0_ready), 64'd0);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        #1;
        check("hold_req0_next", 64'(bus.req0_ready), 64'd1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        check("hold_order_len", 64'(issue_log.size()), 64'd2);
        if (issue_log.size() == 2) begin
            check("hold_order_0", 64'(issue_log[0]), 64'd1);
            check("hold_order_1", 64'(issue_log[1]), 64'd0);
        end
        drain("hold");

        // FIFO full with result side blocked, then return backpressure on head tag 1
        issue_log.delete();
        @(negedge clk);
        bus.req0_x     = fill(16'h3800);
        bus.req1_x     = fill(16'h4200);
        bus.res0_ready = 1'b0;
        bus.res1_ready = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        check("full_issues", 64'(issue_log.size()), 64'd4);
        check("full_tree_valid", 64'(bus.tree_valid), 64'd0);
        check("full_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
        check("full_inflight", 64'(bus.inflight), 64'd4);
        check("full_head_res1", 64'({bus.res1_valid, bus.res0_valid}), 64'b10);
        @(negedge clk);
        bus.res0_ready = 1'b1;
        #1;
        check("bp_next_ready", 64'(bus.tree_next_ready), 64'd0);
        @(negedge clk);
        #1;
        check("bp_no_pop", 64'(bus.inflight), 64'd4);
        bus.res1_ready = 1'b1;
        #1;
        check("bp_release", 64'(bus.tree_next_ready), 64'd1);
        check("full_no_same_cycle", 64'(bus.tree_valid), 64'd0);
        @(negedge clk);
        bus.res0_ready = 1'b0;
        bus.res1_ready = 1'b0;
        #1;
        check("pop_inflight", 64'(bus.inflight), 64'd3);
        check("push_resumes", 64'(bus.tree_valid), 64'd1);
        @(negedge clk);
        #1;
        check("refill_inflight", 64'(bus.inflight), 64'd4);
        check("refill_issues", 64'(issue_log.size()), 64'd5);
        drain("full");

        // Tag error: a result with nothing outstanding
        @(negedge clk);
        inject = 1'b1;
        #1;
        check("err_next_ready", 64'(bus.tree_next_ready), 64'd0);
        check("err_res_valid", 64'({bus.res0_valid, bus.res1_valid}), 64'd0);
        @(negedge clk);
        inject = 1'b0;
        #1;
        check("err_set", 64'(bus.tag_err), 64'd1);
        repeat (3) @(negedge clk);
        #1;
        check("err_sticky", 64'(bus.tag_err), 64'd1);
        rst_n = 1'b0;
        #1;
        check("err_cleared", 64'(bus.tag_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset while req1 is held
        issue_log.delete();
        @(negedge clk);
        bus.req0_x     = fill(16'h3C00);
        bus.req1_x     = fill(16'h4400);
        bus.req1_valid = 1'b1;
        bus.tree_ready = 1'b0;
        @(negedge clk);
        bus.req0_valid = 1'b1;
        #1;
        check("ar_hold_tree_x", (bus.tree_x === fill(16'h4400)) ? 64'd1 : 64'd0, 64'd1);
        #1;
        bus.tree_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check("ar_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
        check("ar_tree_valid", 64'(bus.tree_valid), 64'd0);
        check("ar_inflight", 64'(bus.inflight), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ar_req0_first", 64'({bus.req0_ready, bus.req1_ready}), 64'b10);
        check("ar_tree_x", (bus.tree_x === fill(16'h3C00)) ? 64'd1 : 64'd0, 64'd1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("ar_issue_len", 64'(issue_log.size()), 64'd1);
        drain("ar");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
